// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, constants and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  // Scanner controller states.
  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  // Width of the reported key code: {row[1:0], col[1:0]}.
  localparam int KEY_W = 4;

  // Counter width large enough to hold the largest of the three terminal counts.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  // Index of the lowest active-low row; rows must not be all ones.
  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// sync2: 4-bit two-flop synchronizer, resets to all ones (no row pulled low).
module sync2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  // Two-stage capture of the asynchronous row lines.
  // NOTE: non-blocking assignments make meta and q shift as a true pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 4'b1111;
      q    <= 4'b1111;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: drives the 4x4 matrix columns one at a time, debounces press
// and release on the synchronized rows, and reports each key as a code plus a
// one-cycle strobe. Optional macro KEY_REPEAT_EN adds auto-repeat while held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 100000,
  parameter int REPEAT_CNT   = 5000000
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [3:0]       BTN_X,
  input  logic [3:0]       BTN_Y,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);

  localparam int CW = cnt_width(SCAN_DIV, DEBOUNCE_CNT, REPEAT_CNT);
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CNT - 1);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [1:0]      col, col_n;
  logic [1:0]      row, row_n;
  logic [3:0]      pat, pat_n;
  logic [KEY_W-1:0] code_n;
  logic            valid_n;
  logic            held_n;
  logic [3:0]      ys;

`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CNT - 1);
  logic [CW-1:0]   rpt, rpt_n;
`endif

  // Counters stop at all ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  sync2 u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (BTN_Y),
    .q    (ys)
  );

  // Exactly one column driven low, selected by the column register.
  assign BTN_X = ~(4'b0001 << col);

  // Next-state and output decode for scan, debounce and hold.
  // NOTE: every target gets a default first, so no branch can infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    col_n   = col;
    row_n   = row;
    pat_n   = pat;
    code_n  = key_code;
    valid_n = 1'b0;
    held_n  = key_held;
`ifdef KEY_REPEAT_EN
    rpt_n   = rpt;
`endif
    case (state)
      SCAN: begin
        if (cnt >= DWELL_LAST) begin
          cnt_n = '0;
          if (ys != 4'b1111) begin
            state_n = PRESS_DB;
            pat_n   = ys;
            row_n   = lowest_low(ys);
          end else begin
            col_n = col + 2'd1;
          end
        end else begin
          cnt_n = sat_inc(cnt);
        end
      end
      PRESS_DB: begin
        if (ys == pat) begin
          if (cnt >= DB_LAST) begin
            state_n = HELD;
            cnt_n   = '0;
            valid_n = 1'b1;
            code_n  = {row, col};
            held_n  = 1'b1;
`ifdef KEY_REPEAT_EN
            rpt_n   = '0;
`endif
          end else begin
            cnt_n = sat_inc(cnt);
          end
        end else begin
          state_n = SCAN;
          cnt_n   = '0;
          col_n   = col + 2'd1;
        end
      end
      HELD: begin
`ifdef KEY_REPEAT_EN
        if (rpt >= RPT_LAST) begin
          valid_n = 1'b1;
          rpt_n   = '0;
        end else begin
          rpt_n = sat_inc(rpt);
        end
`endif
        if (ys == 4'b1111) begin
          state_n = REL_DB;
          cnt_n   = '0;
        end
      end
      REL_DB: begin
        if (ys == 4'b1111) begin
          if (cnt >= DB_LAST) begin
            state_n = SCAN;
            cnt_n   = '0;
            held_n  = 1'b0;
            col_n   = col + 2'd1;
          end else begin
            cnt_n = sat_inc(cnt);
          end
        end else begin
          state_n = HELD;
        end
      end
      default: state_n = SCAN;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      cnt       <= '0;
      col       <= 2'd0;
      row       <= 2'd0;
      pat       <= 4'b1111;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt       <= '0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      col       <= col_n;
      row       <= row_n;
      pat       <= pat_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      key_held  <= held_n;
`ifdef KEY_REPEAT_EN
      rpt       <= rpt_n;
`endif
    end
  end

endmodule
